wb_write_arbiter: RTL and testbench
===================================

Name: wb_write_arbiter

Overview:
- Arbitrates functional-unit writebacks onto a 2-write-port physical register file. Sources are add, load, mul, div and done.
- Each source gets a one-entry holding buffer with a valid/ready handshake.
- Up to two writes are granted per cycle by round-robin arbitration. Grants are driven as registered write-port signals to the register file and the wakeup broadcast.
- Handles physical register 0 drops, same-destination conflicts and stall accounting.

Parameters:
- DATA_W, 32, writeback data width
- PHY_W, 8, physical register index width
- NUM_SRC, 5, source count; index 0 add, 1 load, 2 mul, 3 div, 4 done

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- src_valid  in  NUM_SRC  per-source writeback request
- src_data  in  NUM_SRC*DATA_W  per-source data; source i occupies bits [i*DATA_W +: DATA_W]
- src_phy  in  NUM_SRC*PHY_W  per-source destination physical register
- src_ready  out  NUM_SRC  per-source buffer can accept this cycle
- wr_en0  out  1  write port 0 enable
- wr_phy0  out  PHY_W  write port 0 index
- wr_data0  out  DATA_W  write port 0 data
- wr_en1  out  1  write port 1 enable
- wr_phy1  out  PHY_W  write port 1 index
- wr_data1  out  DATA_W  write port 1 data
- conflict_err  out  1  sticky: same-phy collision seen
- stall_cnt  out  16  saturating count of cycles with a pending, ungranted entry

Behaviour:
- Reset (reset=0, asynchronous): all hold_valid=0, all wr_* =0, rr_ptr=0, conflict_err=0, stall_cnt=0. Entries in flight are dropped. src_ready is all 1 while no entry is held.
- Handshake: a source is accepted on a clock edge when src_valid[i] & src_ready[i]. Data and phy are captured into hold[i].
- src_ready[i] = !hold_valid[i] | release[i]. release[i] is true when hold[i] is granted this cycle or hold[i] is being dropped this cycle (combinational).
- Drop: a held entry with phy==0 releases at the next edge without using a port. It is not counted as a grant and never asserts wr_en.
- Pending set: the held entries with phy!=0.
- Scan: each cycle, scan the pending set from rr_ptr upward mod NUM_SRC.
  - The first pending entry gets port 0.
  - The next pending entry whose phy differs from port 0's phy gets port 1.
  - Entries skipped only for matching port 0's phy stay held.
- Same-phy collision: if a pending entry is skipped because its phy equals port 0's phy, conflict_err is set on that edge. It stays set until reset.
- Outputs are registered: wr_enN/wr_phyN/wr_dataN load the granted entry at the edge. wr_enN=0 when that port has no grant; its phy/data then hold their previous values.
- Latency: src_valid high in cycle t with the buffer empty gives the write visible in cycle t+2. With continuous back-to-back traffic on one source, throughput is one write per cycle (release allows same-edge refill).
- rr_ptr update: if any grant, rr_ptr <= (index of last granted source + 1) mod NUM_SRC; otherwise unchanged.
- stall_cnt: increments at an edge when at least one pending entry is not granted. It saturates at 16'hFFFF.
- Simultaneous refill: release and a new accept on the same edge means hold[i] is overwritten with the new request and hold_valid stays 1.

Test Plan:
- Reset: hold reset=0 with random inputs. Required: wr_en0=wr_en1=0, conflict_err=0, stall_cnt=0, src_ready=5'b11111. Release reset, then drive src_valid for one cycle and confirm it is accepted.
- Single write: src0 valid in cycle t with phy=0x25, data=0xDEADBEEF. Required: in cycle t+2, wr_en0=1, wr_phy0=0x25, wr_data0=0xDEADBEEF, wr_en1=0. rr_ptr becomes 1.
- Full contention: all five sources valid together, phys 0x21..0x25, held until ready, rr_ptr=0. Required grants: {0,1}, then {2,3}, then {4 on port 0, port 1 idle}. src_ready[i] rises only on release. stall_cnt=2.
- Drop phy 0: load sends phy=0x00 with data=0x1234. Required: no wr_en asserted, src_ready[1] stays high the following cycle, stall_cnt unchanged.
- Collision: mul and div both send phy=0x30, rr_ptr=2. Required: mul is written on port 0 first, div on port 0 the next cycle, conflict_err=1 sticky, stall_cnt +1.
- Reset mid-flight: three entries held, then reset is pulsed low for less than half a cycle between edges. Required: wr_en=0 immediately, all holds cleared, the held entries are never written after release, rr_ptr=0.

Source files
------------

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_write_arbiter
// Purpose  : Round-robin arbiter that takes NUM_SRC writeback sources and
//            drives the two register-file write ports through one-entry
//            holding buffers.
// Revision : 1.0 - initial release
// ============================================================================
module wb_write_arbiter #(
  parameter int DATA_W  = 32,
  parameter int PHY_W   = 8,
  parameter int NUM_SRC = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  input  logic [NUM_SRC*PHY_W-1:0]    src_phy,
  output logic [NUM_SRC-1:0]          src_ready,
  output logic                        wr_en0,
  output logic [PHY_W-1:0]            wr_phy0,
  output logic [DATA_W-1:0]           wr_data0,
  output logic                        wr_en1,
  output logic [PHY_W-1:0]            wr_phy1,
  output logic [DATA_W-1:0]           wr_data1,
  output logic                        conflict_err,
  output logic [15:0]                 stall_cnt
);

  localparam int c_PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] r_hold_valid;
  logic [DATA_W-1:0]  r_hold_data [NUM_SRC];
  logic [PHY_W-1:0]   r_hold_phy  [NUM_SRC];
  logic [c_PTR_W-1:0] r_rr_ptr;
  logic               r_wr_en0, r_wr_en1;
  logic [PHY_W-1:0]   r_wr_phy0, r_wr_phy1;
  logic [DATA_W-1:0]  r_wr_data0, r_wr_data1;
  logic               r_conflict;
  logic [15:0]        r_stall_cnt;

  logic [NUM_SRC-1:0] w_pending, w_drop, w_grant, w_release;
  logic               w_g0_vld, w_g1_vld, w_collide, w_stall;
  logic [c_PTR_W-1:0] w_g0_idx, w_g1_idx, w_last, w_rr_next;
  logic [c_PTR_W:0]   w_scan;

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      // Writes to physical register 0 are discarded without using a port.
      assign w_pending[i] = r_hold_valid[i] && (r_hold_phy[i] != '0);
      assign w_drop[i]    = r_hold_valid[i] && (r_hold_phy[i] == '0);
      assign w_grant[i]   = (w_g0_vld && (w_g0_idx == c_PTR_W'(i))) ||
                            (w_g1_vld && (w_g1_idx == c_PTR_W'(i)));
      assign w_release[i] = w_grant[i] || w_drop[i];
      assign src_ready[i] = !r_hold_valid[i] || w_release[i];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_hold_valid[i] <= 1'b0;
          r_hold_data[i]  <= '0;
          r_hold_phy[i]   <= '0;
        end else if (src_valid[i] && src_ready[i]) begin
          r_hold_valid[i] <= 1'b1;
          r_hold_data[i]  <= src_data[i*DATA_W +: DATA_W];
          r_hold_phy[i]   <= src_phy[i*PHY_W +: PHY_W];
        end else if (w_release[i]) begin
          r_hold_valid[i] <= 1'b0;
        end
      end
    end
  endgenerate

  // Scan from the round-robin pointer; port 1 must not target port 0's register.
  always_comb begin
    w_g0_vld  = 1'b0;
    w_g0_idx  = '0;
    w_g1_vld  = 1'b0;
    w_g1_idx  = '0;
    w_collide = 1'b0;
    w_stall   = 1'b0;
    w_scan    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_scan = {1'b0, r_rr_ptr} + (c_PTR_W+1)'(k);
      if (w_scan >= (c_PTR_W+1)'(NUM_SRC))
        w_scan = w_scan - (c_PTR_W+1)'(NUM_SRC);
      if (w_pending[w_scan[c_PTR_W-1:0]]) begin
        if (!w_g0_vld) begin
          w_g0_vld = 1'b1;
          w_g0_idx = w_scan[c_PTR_W-1:0];
        end else if (r_hold_phy[w_scan[c_PTR_W-1:0]] == r_hold_phy[w_g0_idx]) begin
          w_collide = 1'b1;
          w_stall   = 1'b1;
        end else if (!w_g1_vld) begin
          w_g1_vld = 1'b1;
          w_g1_idx = w_scan[c_PTR_W-1:0];
        end else begin
          w_stall = 1'b1;
        end
      end
    end
  end

  assign w_last    = w_g1_vld ? w_g1_idx : w_g0_idx;
  assign w_rr_next = (w_last == c_PTR_W'(NUM_SRC-1)) ? '0 : w_last + c_PTR_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr    <= '0;
      r_wr_en0    <= 1'b0;
      r_wr_phy0   <= '0;
      r_wr_data0  <= '0;
      r_wr_en1    <= 1'b0;
      r_wr_phy1   <= '0;
      r_wr_data1  <= '0;
      r_conflict  <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_wr_en0 <= w_g0_vld;
      r_wr_en1 <= w_g1_vld;
      if (w_g0_vld) begin
        r_wr_phy0  <= r_hold_phy[w_g0_idx];
        r_wr_data0 <= r_hold_data[w_g0_idx];
        r_rr_ptr   <= w_rr_next;
      end
      if (w_g1_vld) begin
        r_wr_phy1  <= r_hold_phy[w_g1_idx];
        r_wr_data1 <= r_hold_data[w_g1_idx];
      end
      if (w_collide)
        r_conflict <= 1'b1;
      if (w_stall && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign wr_en0       = r_wr_en0;
  assign wr_phy0      = r_wr_phy0;
  assign wr_data0     = r_wr_data0;
  assign wr_en1       = r_wr_en1;
  assign wr_phy1      = r_wr_phy1;
  assign wr_data1     = r_wr_data1;
  assign conflict_err = r_conflict;
  assign stall_cnt    = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_write_arbiter
// Purpose  : Scoreboard bench for wb_write_arbiter; expected port writes are
//            queued with the stimulus and matched against the write ports.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_write_arbiter;

  localparam int DATA_W  = 32;
  localparam int PHY_W   = 8;
  localparam int NUM_SRC = 5;

  logic                      clk;
  logic                      reset;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC*PHY_W-1:0]  src_phy;
  logic [NUM_SRC-1:0]        src_ready;
  logic                      wr_en0, wr_en1;
  logic [PHY_W-1:0]          wr_phy0, wr_phy1;
  logic [DATA_W-1:0]         wr_data0, wr_data1;
  logic                      conflict_err;
  logic [15:0]               stall_cnt;

  typedef struct {
    bit               port;
    logic [PHY_W-1:0] phy;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  wb_write_arbiter #(.DATA_W(DATA_W), .PHY_W(PHY_W), .NUM_SRC(NUM_SRC)) dut (
    .clk          (clk),
    .reset        (reset),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_phy      (src_phy),
    .src_ready    (src_ready),
    .wr_en0       (wr_en0),
    .wr_phy0      (wr_phy0),
    .wr_data0     (wr_data0),
    .wr_en1       (wr_en1),
    .wr_phy1      (wr_phy1),
    .wr_data1     (wr_data1),
    .conflict_err (conflict_err),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [PHY_W-1:0] phy, input logic [DATA_W-1:0] data);
    src_valid[i]               = 1'b1;
    src_phy[i*PHY_W +: PHY_W]  = phy;
    src_data[i*DATA_W +: DATA_W] = data;
  endtask

  task automatic expect_wr(input bit port, input logic [PHY_W-1:0] phy, input logic [DATA_W-1:0] data);
    exp_t e;
    e.port = port;
    e.phy  = phy;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input bit port, input logic [PHY_W-1:0] phy, input logic [DATA_W-1:0] data);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_wr", {56'd0, phy}, 64'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check("wr_port", 64'(port), 64'(e.port));
      check("wr_phy",  64'(phy),  64'(e.phy));
      check("wr_data", 64'(data), 64'(e.data));
    end
  endtask

  // Write-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (wr_en0) pop_check(1'b0, wr_phy0, wr_data0);
      if (wr_en1) pop_check(1'b1, wr_phy1, wr_data1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    src_valid = '0;
    src_data  = '0;
    src_phy   = '0;

    // Reset held with random inputs
    repeat (3) begin
      tick();
      src_valid = NUM_SRC'($urandom);
      src_data  = {$urandom, $urandom, $urandom, $urandom, $urandom};
      src_phy   = NUM_SRC*PHY_W'({$urandom, $urandom});
    end
    #2;
    check("rst_wr_en0", 64'(wr_en0), 64'd0);
    check("rst_wr_en1", 64'(wr_en1), 64'd0);
    check("rst_conflict", 64'(conflict_err), 64'd0);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    check("rst_ready", 64'(src_ready), 64'h1F);
    tick();
    reset     = 1'b1;
    src_valid = '0;

    // One-cycle request after reset (src4 -> rr_ptr wraps to 0)
    tick();
    check("idle_ready", 64'(src_ready), 64'h1F);
    drive(4, 8'h11, 32'hA5A5_A5A5);
    expect_wr(1'b0, 8'h11, 32'hA5A5_A5A5);
    tick();
    src_valid = '0;
    tick();
    tick();

    // Full contention from rr_ptr=0
    for (int i = 0; i < NUM_SRC; i++) drive(i, PHY_W'(8'h21 + i), 32'hC0DE_0000 + i);
    expect_wr(1'b0, 8'h21, 32'hC0DE_0000);
    expect_wr(1'b1, 8'h22, 32'hC0DE_0001);
    expect_wr(1'b0, 8'h23, 32'hC0DE_0002);
    expect_wr(1'b1, 8'h24, 32'hC0DE_0003);
    expect_wr(1'b0, 8'h25, 32'hC0DE_0004);
    tick();
    src_valid = '0;
    check("cont_ready1", 64'(src_ready), 64'h03);
    tick();
    check("cont_ready2", 64'(src_ready), 64'h0F);
    tick();
    check("cont_ready3", 64'(src_ready), 64'h1F);
    tick();
    check("cont_wr_en1_idle", 64'(wr_en1), 64'd0);
    check("cont_stall", 64'(stall_cnt), 64'd2);

    // Single write on src0
    tick();
    drive(0, 8'h25, 32'hDEAD_BEEF);
    expect_wr(1'b0, 8'h25, 32'hDEAD_BEEF);
    tick();
    src_valid = '0;
    tick();
    check("single_en0", 64'(wr_en0), 64'd1);
    check("single_phy0", 64'(wr_phy0), 64'h25);
    check("single_data0", 64'(wr_data0), 64'hDEAD_BEEF);
    check("single_en1", 64'(wr_en1), 64'd0);

    // Drop of phy 0 on load
    tick();
    drive(1, 8'h00, 32'h0000_1234);
    tick();
    src_valid = '0;
    check("drop_ready", 64'(src_ready[1]), 64'd1);
    tick();
    check("drop_en0", 64'(wr_en0), 64'd0);
    check("drop_en1", 64'(wr_en1), 64'd0);
    check("drop_stall", 64'(stall_cnt), 64'd2);

    // src1 write moves rr_ptr to 2
    tick();
    drive(1, 8'h40, 32'hCAFE_0001);
    expect_wr(1'b0, 8'h40, 32'hCAFE_0001);
    tick();
    src_valid = '0;
    tick();
    tick();

    // Same-phy collision between mul and div
    check("pre_conflict", 64'(conflict_err), 64'd0);
    drive(2, 8'h30, 32'h1111_0002);
    drive(3, 8'h30, 32'h1111_0003);
    expect_wr(1'b0, 8'h30, 32'h1111_0002);
    expect_wr(1'b0, 8'h30, 32'h1111_0003);
    tick();
    src_valid = '0;
    check("coll_ready", 64'(src_ready), 64'h17);
    tick();
    check("coll_conflict", 64'(conflict_err), 64'd1);
    check("coll_stall", 64'(stall_cnt), 64'd3);
    tick();
    tick();
    check("coll_sticky", 64'(conflict_err), 64'd1);
    check("coll_stall_hold", 64'(stall_cnt), 64'd3);

    // Reset mid-flight, rr_ptr=4: src4/src0 write, 1..3 stay held
    for (int i = 0; i < NUM_SRC; i++) drive(i, PHY_W'(8'h61 + i), 32'hBEEF_0000 + i);
    tick();
    src_valid = '0;
    tick();
    check("mid_en0", 64'(wr_en0), 64'd1);
    check("mid_phy0", 64'(wr_phy0), 64'h65);
    check("mid_en1", 64'(wr_en1), 64'd1);
    check("mid_phy1", 64'(wr_phy1), 64'h61);
    reset = 1'b0;
    #1;
    check("mid_rst_en0", 64'(wr_en0), 64'd0);
    check("mid_rst_en1", 64'(wr_en1), 64'd0);
    check("mid_rst_ready", 64'(src_ready), 64'h1F);
    check("mid_rst_conflict", 64'(conflict_err), 64'd0);
    check("mid_rst_stall", 64'(stall_cnt), 64'd0);
    #1;
    reset = 1'b1;

    // rr_ptr back at 0: src0 on port 0, src4 on port 1
    tick();
    drive(0, 8'h71, 32'h7777_0000);
    drive(4, 8'h74, 32'h7777_0004);
    expect_wr(1'b0, 8'h71, 32'h7777_0000);
    expect_wr(1'b1, 8'h74, 32'h7777_0004);
    tick();
    src_valid = '0;
    repeat (4) tick();
    check("final_stall", 64'(stall_cnt), 64'd0);
    check("final_conflict", 64'(conflict_err), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
